// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl_pkg                                                |
// | Description : Shared definitions for the pipeline controller: FSM state    |
// |               encoding and the default timeout / counter-width values.     |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipe_ctrl_pkg;

    // Controller FSM states; the numeric values are visible on state_o.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    // Maximum number of MEM_WAIT cycles before the access is abandoned.
    localparam int c_TIMEOUT_DEFAULT = 64;
    // Width of the stall / flush performance counters.
    localparam int c_CNT_W_DEFAULT   = 16;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl_if                                                 |
// | Description : Signal bundle between the pipeline datapath and its          |
// |               controller.                                                  |
// | Ports       : start_i, halt_i, idex_memread_i, idex_rd_i, ifid_rs1_i,      |
// |               ifid_rs2_i, branch_taken_i, dmem_req_i, dmem_ack_i           |
// |                 -> pipeline status into the controller                     |
// |               pc_write_o, ifid_write_o, exmem_write_o, memwb_write_o,      |
// |               ifid_flush_o, idex_bubble_o, state_o, timeout_o,             |
// |               stall_cnt_o, flush_cnt_o                                     |
// |                 -> controls and status out of the controller               |
// |               modport master : datapath side (drives the *_i signals)      |
// |               modport slave  : controller side (drives the *_o signals)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pipe_ctrl_if #(
    parameter int CNT_W = pipe_ctrl_pkg::c_CNT_W_DEFAULT
);
    logic             start_i;
    logic             halt_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rd_i;
    logic [4:0]       ifid_rs1_i;
    logic [4:0]       ifid_rs2_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;

    logic             pc_write_o;
    logic             ifid_write_o;
    logic             exmem_write_o;
    logic             memwb_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic [1:0]       state_o;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output start_i, halt_i, idex_memread_i, idex_rd_i, ifid_rs1_i,
               ifid_rs2_i, branch_taken_i, dmem_req_i, dmem_ack_i,
        input  pc_write_o, ifid_write_o, exmem_write_o, memwb_write_o,
               ifid_flush_o, idex_bubble_o, state_o, timeout_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  start_i, halt_i, idex_memread_i, idex_rd_i, ifid_rs1_i,
               ifid_rs2_i, branch_taken_i, dmem_req_i, dmem_ack_i,
        output pc_write_o, ifid_write_o, exmem_write_o, memwb_write_o,
               ifid_flush_o, idex_bubble_o, state_o, timeout_o,
               stall_cnt_o, flush_cnt_o
    );

endinterface : pipe_ctrl_if
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_detect                                                |
// | Description : Load-use hazard compare. Flags when the instruction in ID/EX |
// |               is a load whose destination (other than x0) is a source of   |
// |               the instruction in IF/ID.                                    |
// | Ports       : i_memread  in  1  ID/EX instruction is a load                |
// |               i_rd       in  5  ID/EX destination register                 |
// |               i_rs1      in  5  IF/ID source register 1                    |
// |               i_rs2      in  5  IF/ID source register 2                    |
// |               o_hazard   out 1  load-use hazard present                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_detect (
    input  wire logic       i_memread,
    input  wire logic [4:0] i_rd,
    input  wire logic [4:0] i_rs1,
    input  wire logic [4:0] i_rs2,
    output logic            o_hazard
);

    // x0 is hardwired to zero, so a load into it never creates a dependency.
    always_comb begin
        o_hazard = i_memread && (i_rd != 5'd0) &&
                   ((i_rd == i_rs1) || (i_rd == i_rs2));
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl                                                    |
// | Description : Five-stage pipeline controller. Generates stage-register     |
// |               load enables, IF/ID flush and ID/EX bubble for load-use      |
// |               hazards, branches and data-memory wait states; tracks a      |
// |               memory timeout and stall / flush performance counters.       |
// | Ports       : clk_i  in  1   clock, rising edge                            |
// |               rst_i  in  1   asynchronous reset, active low                |
// |               bus    slave   pipe_ctrl_if (status in, controls out)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT,
    parameter int CNT_W   = c_CNT_W_DEFAULT
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    pipe_ctrl_if.slave bus
);

    localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e                r_state_q,     w_state_d;
    logic [c_WAIT_W-1:0]   r_wait_cnt_q,  w_wait_cnt_d;
    logic                  r_halt_lat_q,  w_halt_lat_d;
    logic                  r_timeout_q,   w_timeout_d;
    logic [CNT_W-1:0]      r_stall_cnt_q, w_stall_cnt_d;
    logic [CNT_W-1:0]      r_flush_cnt_q, w_flush_cnt_d;

    logic w_hazard;
    logic w_memstall;
    logic w_run_rules;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_exmem_write;
    logic w_memwb_write;
    logic w_ifid_flush;
    logic w_idex_bubble;

    hazard_detect u_hazard_detect (
        .i_memread (bus.idex_memread_i),
        .i_rd      (bus.idex_rd_i),
        .i_rs1     (bus.ifid_rs1_i),
        .i_rs2     (bus.ifid_rs2_i),
        .o_hazard  (w_hazard)
    );

    // A request completed in the same cycle costs nothing.
    assign w_memstall = bus.dmem_req_i && !bus.dmem_ack_i;

    // ------------------------------------------------------------------
    // Next-state and control outputs. Outputs are purely combinational
    // so that a stall freezes the pipeline in the very cycle it is seen.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_wait_cnt_d  = r_wait_cnt_q;
        w_halt_lat_d  = r_halt_lat_q;
        w_timeout_d   = r_timeout_q;
        w_run_rules   = 1'b0;
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_exmem_write = 1'b0;
        w_memwb_write = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (w_memstall) begin
                    // Memory stall wins over hazard and halt. A halt seen
                    // here is held until the outstanding access completes.
                    w_state_d    = ST_MEM_WAIT;
                    w_wait_cnt_d = '0;
                    w_halt_lat_d = bus.halt_i;
                end else begin
                    w_run_rules = 1'b1;
                    if (bus.halt_i) begin
                        w_state_d = ST_HALT;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (bus.dmem_ack_i) begin
                    // Completion cycle behaves like an ordinary RUN cycle.
                    w_run_rules  = 1'b1;
                    w_halt_lat_d = 1'b0;
                    w_state_d    = (r_halt_lat_q || bus.halt_i) ? ST_HALT : ST_RUN;
                end else if (r_wait_cnt_q == c_WAIT_W'(TIMEOUT - 1)) begin
                    w_timeout_d  = 1'b1;
                    w_halt_lat_d = 1'b0;
                    w_state_d    = ST_HALT;
                end else begin
                    w_wait_cnt_d = r_wait_cnt_q + 1'b1;
                    if (bus.halt_i) begin
                        w_halt_lat_d = 1'b1;
                    end
                end
            end

            default: begin
                // ST_HALT: everything held off; only reset leaves.
            end
        endcase

        if (w_run_rules) begin
            w_exmem_write = 1'b1;
            w_memwb_write = 1'b1;
            if (w_hazard) begin
                // Freeze PC and IF/ID, inject a bubble. The branch is not
                // taken now; it is resolved again once the load completes.
                w_idex_bubble = 1'b1;
            end else begin
                w_pc_write   = 1'b1;
                w_ifid_write = 1'b1;
                w_ifid_flush = bus.branch_taken_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (((r_state_q == ST_RUN) || (r_state_q == ST_MEM_WAIT)) &&
            !w_pc_write && (r_stall_cnt_q != '1)) begin
            w_stall_cnt_d = r_stall_cnt_q + 1'b1;
        end
        if (w_ifid_flush && (r_flush_cnt_q != '1)) begin
            w_flush_cnt_d = r_flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state_q     <= ST_IDLE;
            r_wait_cnt_q  <= '0;
            r_halt_lat_q  <= 1'b0;
            r_timeout_q   <= 1'b0;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_wait_cnt_q  <= w_wait_cnt_d;
            r_halt_lat_q  <= w_halt_lat_d;
            r_timeout_q   <= w_timeout_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign bus.pc_write_o    = w_pc_write;
    assign bus.ifid_write_o  = w_ifid_write;
    assign bus.exmem_write_o = w_exmem_write;
    assign bus.memwb_write_o = w_memwb_write;
    assign bus.ifid_flush_o  = w_ifid_flush;
    assign bus.idex_bubble_o = w_idex_bubble;
    assign bus.state_o       = r_state_q;
    assign bus.timeout_o     = r_timeout_q;
    assign bus.stall_cnt_o   = r_stall_cnt_q;
    assign bus.flush_cnt_o   = r_flush_cnt_q;

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_ctrl                                                 |
// | Description : Self-checking bench for pipe_ctrl. One stimulus/expectation  |
// |               record per clock cycle, plus hand-written reset sequences.   |
// |               Built with TIMEOUT=4 and 3-bit counters so the timeout and   |
// |               counter saturation are reached quickly.                      |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       halt;
        logic       memread;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       req;
        logic       ack;
        logic [3:0] en;     // {pc, ifid, exmem, memwb}
        logic       flush;
        logic       bubble;
        logic [1:0] st;
        logic       to;
        logic [2:0] sc;
        logic [2:0] fc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst_n, input logic start, input logic halt,
                       input logic memread, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic br, input logic req, input logic ack,
                       input logic [3:0] en, input logic flush, input logic bubble,
                       input logic [1:0] st, input logic to,
                       input logic [2:0] sc, input logic [2:0] fc);
        vec_t v;
        v.rst_n = rst_n; v.start = start; v.halt = halt; v.memread = memread;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.br = br; v.req = req; v.ack = ack;
        v.en = en; v.flush = flush; v.bubble = bubble; v.st = st; v.to = to;
        v.sc = sc; v.fc = fc;
        vecs.push_back(v);
    endtask

    function automatic logic [3:0] en_now();
        return {bus.pc_write_o, bus.ifid_write_o, bus.exmem_write_o, bus.memwb_write_o};
    endfunction

    task automatic check_outs(input string name, input logic [3:0] en,
                              input logic flush, input logic bubble,
                              input logic [1:0] st, input logic to,
                              input logic [2:0] sc, input logic [2:0] fc);
        logic [14:0] got, req;
        got = {en_now(), bus.ifid_flush_o, bus.idex_bubble_o, bus.state_o,
               bus.timeout_o, bus.stall_cnt_o, bus.flush_cnt_o};
        req = {en, flush, bubble, st, to, sc, fc};
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got en=%b fl=%b bu=%b st=%0d to=%b sc=%0d fc=%0d, required en=%b fl=%b bu=%b st=%0d to=%b sc=%0d fc=%0d",
                     name, en_now(), bus.ifid_flush_o, bus.idex_bubble_o, bus.state_o,
                     bus.timeout_o, bus.stall_cnt_o, bus.flush_cnt_o,
                     en, flush, bubble, st, to, sc, fc);
        end
    endtask

    task automatic drive_idle_inputs();
        bus.start_i = 1'b0; bus.halt_i = 1'b0; bus.idex_memread_i = 1'b0;
        bus.idex_rd_i = 5'd0; bus.ifid_rs1_i = 5'd0; bus.ifid_rs2_i = 5'd0;
        bus.branch_taken_i = 1'b0; bus.dmem_req_i = 1'b0; bus.dmem_ack_i = 1'b0;
    endtask

    initial begin
        logic found;
        drive_idle_inputs();

        //   rst st hl mr rd     rs1    rs2    br rq ak en       fl bu st    to sc    fc
        // idle; start is the only way out
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        add(1, 0, 1, 1, 5'd5,  5'd0,  5'd5,  1, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        add(1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b1111, 0, 0, 2'd1, 0, 3'd0, 3'd0);
        // load-use on rs2, then x0 load, rs1 hazard, no-load match
        add(1, 0, 0, 1, 5'd5,  5'd0,  5'd5,  0, 0, 0, 4'b0011, 0, 1, 2'd1, 0, 3'd0, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b1111, 0, 0, 2'd1, 0, 3'd1, 3'd0);
        add(1, 0, 0, 1, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b1111, 0, 0, 2'd1, 0, 3'd1, 3'd0);
        add(1, 0, 0, 1, 5'd7,  5'd7,  5'd0,  0, 0, 0, 4'b0011, 0, 1, 2'd1, 0, 3'd1, 3'd0);
        add(1, 0, 0, 0, 5'd5,  5'd5,  5'd0,  0, 0, 0, 4'b1111, 0, 0, 2'd1, 0, 3'd2, 3'd0);
        // branch suppressed by hazard, taken next cycle
        add(1, 0, 0, 1, 5'd3,  5'd3,  5'd0,  1, 0, 0, 4'b0011, 0, 1, 2'd1, 0, 3'd2, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  1, 0, 0, 4'b1111, 1, 0, 2'd1, 0, 3'd3, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b1111, 0, 0, 2'd1, 0, 3'd3, 3'd1);
        // memory wait: ack three cycles after the request
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd1, 0, 3'd3, 3'd1);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd2, 0, 3'd4, 3'd1);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd2, 0, 3'd5, 3'd1);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 1, 4'b1111, 0, 0, 2'd2, 0, 3'd6, 3'd1);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b1111, 0, 0, 2'd1, 0, 3'd6, 3'd1);
        // req and ack together: no stall
        add(1, 0, 0, 1, 5'd9,  5'd1,  5'd2,  0, 1, 1, 4'b1111, 0, 0, 2'd1, 0, 3'd6, 3'd1);
        // memstall overrides hazard and branch; ack cycle applies hazard rule
        add(1, 0, 0, 1, 5'd5,  5'd0,  5'd5,  1, 1, 0, 4'b0000, 0, 0, 2'd1, 0, 3'd6, 3'd1);
        add(1, 0, 0, 1, 5'd5,  5'd0,  5'd5,  1, 1, 1, 4'b0011, 0, 1, 2'd2, 0, 3'd7, 3'd1);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  1, 0, 0, 4'b1111, 1, 0, 2'd1, 0, 3'd7, 3'd1);
        // deferred halt; stall counter saturated at 7
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd1, 0, 3'd7, 3'd2);
        add(1, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd2, 0, 3'd7, 3'd2);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd2, 0, 3'd7, 3'd2);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 1, 4'b1111, 0, 0, 2'd2, 0, 3'd7, 3'd2);
        add(1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  1, 1, 1, 4'b0000, 0, 0, 2'd3, 0, 3'd7, 3'd2);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b0000, 0, 0, 2'd3, 0, 3'd7, 3'd2);
        // reset, new start required, halt in RUN with taken branch
        add(0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        add(1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        add(1, 0, 1, 0, 5'd0,  5'd0,  5'd0,  1, 0, 0, 4'b1111, 1, 0, 2'd1, 0, 3'd0, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  1, 0, 0, 4'b0000, 0, 0, 2'd3, 0, 3'd0, 3'd1);
        // timeout after 4 MEM_WAIT cycles without ack
        add(0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        add(1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd1, 0, 3'd0, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd2, 0, 3'd1, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd2, 0, 3'd2, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd2, 0, 3'd3, 3'd0);
        add(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 4'b0000, 0, 0, 2'd2, 0, 3'd4, 3'd0);
        add(1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 1, 4'b0000, 0, 0, 2'd3, 1, 3'd5, 3'd0);
        add(0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);

        // Asynchronous reset before any clock edge.
        #2 rst_i = 1'b0;
        #1 check_outs("reset_async_initial", 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        @(posedge clk_i); #1 rst_i = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk_i); #1;
            rst_i              = vecs[i].rst_n;
            bus.start_i        = vecs[i].start;
            bus.halt_i         = vecs[i].halt;
            bus.idex_memread_i = vecs[i].memread;
            bus.idex_rd_i      = vecs[i].rd;
            bus.ifid_rs1_i     = vecs[i].rs1;
            bus.ifid_rs2_i     = vecs[i].rs2;
            bus.branch_taken_i = vecs[i].br;
            bus.dmem_req_i     = vecs[i].req;
            bus.dmem_ack_i     = vecs[i].ack;
            @(negedge clk_i);
            check_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].flush,
                       vecs[i].bubble, vecs[i].st, vecs[i].to, vecs[i].sc, vecs[i].fc);
        end

        // Reset in the middle of MEM_WAIT abandons the access.
        @(posedge clk_i); #1;
        drive_idle_inputs();
        rst_i       = 1'b1;
        bus.start_i = 1'b1;
        @(posedge clk_i); #1;
        bus.start_i    = 1'b0;
        bus.dmem_req_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 5 && !found; k++) begin
            @(negedge clk_i);
            if (bus.state_o == 2'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_mem_wait: state_o=%0d required 2 within 5 cycles", bus.state_o);
        end
        #2 rst_i = 1'b0;
        #1 check_outs("reset_mid_mem_wait", 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        @(posedge clk_i); #1;
        rst_i          = 1'b1;
        bus.dmem_ack_i = 1'b1;
        @(negedge clk_i);
        check_outs("after_reset_no_start_1", 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);
        @(negedge clk_i);
        check_outs("after_reset_no_start_2", 4'b0000, 0, 0, 2'd0, 0, 3'd0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of MEM_WAIT cycles before an abort.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-003 The block SHALL have the following ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- start_i  in  1  one-cycle pulse that leaves IDLE.
- halt_i  in  1  program end detected at WB.
- idex_memread_i  in  1  the ID/EX instruction is a load.
- idex_rd_i  in  5  ID/EX destination register.
- ifid_rs1_i, ifid_rs2_i  in  5 each  IF/ID source registers.
- branch_taken_i  in  1  branch resolved taken in ID.
- dmem_req_i  in  1  MEM-stage data access issued this cycle.
- dmem_ack_i  in  1  data memory completes the access.
- pc_write_o, ifid_write_o, exmem_write_o, memwb_write_o  out  1 each  stage-register load enables.
- ifid_flush_o  out  1  zero the IF/ID register.
- idex_bubble_o  out  1  load zero controls into ID/EX.
- state_o  out  2  current FSM state.
- timeout_o  out  1  sticky memory-timeout flag.
- stall_cnt_o, flush_cnt_o  out  CNT_W each  performance counters.

Function
REQ-004 FSM states SHALL be IDLE=0, RUN=1, MEM_WAIT=2, HALT=3, and state_o SHALL equal the current state.
REQ-005 In IDLE and HALT, all enables, ifid_flush_o and idex_bubble_o SHALL be 0.
REQ-006 IDLE SHALL go to RUN on start_i; start_i SHALL be ignored in every other state.
REQ-007 hazard SHALL be 1 when idex_memread_i=1, idex_rd_i!=0, and idex_rd_i equals ifid_rs1_i or ifid_rs2_i.
REQ-008 memstall SHALL be 1 when dmem_req_i=1 and dmem_ack_i=0.
REQ-009 In RUN with no hazard and no memstall, all four enables SHALL be 1, and ifid_flush_o SHALL equal branch_taken_i.
REQ-010 In RUN with hazard and no memstall, the outputs SHALL be pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, exmem_write_o=1, memwb_write_o=1 and ifid_flush_o=0; the branch is suppressed and re-resolved next cycle.
REQ-011 In RUN with memstall, all enables SHALL be 0 in the same cycle, the FSM SHALL go to MEM_WAIT, bubble and flush SHALL be 0, and memstall SHALL override hazard.
REQ-012 Outputs SHALL be combinational from state and inputs, so the stall takes effect with zero cycles of latency.
REQ-013 In MEM_WAIT, all enables SHALL be 0 while dmem_ack_i=0.
REQ-014 In MEM_WAIT, the cycle in which dmem_ack_i=1 SHALL apply the RUN rules (REQ-009/010) and return the FSM to RUN.
REQ-015 If dmem_req_i and dmem_ack_i are both 1 in the same cycle, no stall SHALL occur.
REQ-016 wait_cnt SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without ack.
REQ-017 When wait_cnt reaches TIMEOUT-1 without ack, timeout_o SHALL be set and the FSM SHALL go to HALT.
REQ-018 halt_i in RUN SHALL move the FSM to HALT next cycle, and the current-cycle outputs SHALL follow the RUN rules.
REQ-019 halt_i in MEM_WAIT SHALL be latched and take effect on the ack cycle, with HALT entered instead of RUN.
REQ-020 HALT SHALL be exited only by reset.
REQ-021 timeout_o SHALL stay 1 until reset.
REQ-022 stall_cnt_o SHALL increment on each cycle in RUN or MEM_WAIT with pc_write_o=0, saturating at all-ones.
REQ-023 flush_cnt_o SHALL increment on each cycle with ifid_flush_o=1, saturating at all-ones.

Reset
REQ-024 With rst_i=0, the following SHALL hold immediately and asynchronously:
- state IDLE;
- wait_cnt, halt latch, timeout_o, stall_cnt_o and flush_cnt_o at 0;
- all combinational outputs at their IDLE values.
REQ-025 Reset asserted mid-MEM_WAIT SHALL abandon the access, and the block SHALL then require a new start_i.

Structure
REQ-026 The state encoding, the TIMEOUT default and the CNT_W default SHALL live in shared package pipe_ctrl_pkg.
REQ-027 The REQ-007 compare SHALL be a separate combinational sub-module, hazard_detect.
REQ-028 The whole block SHALL fit in roughly 150-250 lines.

Verification
REQ-029 Load-use: RUN, idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5 -> one cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, and stall_cnt_o=1.
REQ-030 x0 load: the same stimulus with idex_rd_i=0 -> no stall and stall_cnt_o unchanged.
REQ-031 Memory wait: dmem_req_i=1 held with ack arriving 3 cycles later -> enables 0 for 3 cycles with state_o=2, enables 1 on the ack cycle, and stall_cnt_o=3.
REQ-032 Branch plus hazard: branch_taken_i=1 with hazard -> ifid_flush_o=0 and bubble=1; branch still taken next cycle with no hazard -> ifid_flush_o=1 and flush_cnt_o=1.
REQ-033 Timeout: TIMEOUT=4, dmem_ack_i held at 0 -> timeout_o=1 and state_o=3 after 4 MEM_WAIT cycles; enables stay 0 until rst_i=0.
REQ-034 Deferred halt: halt_i pulsed in MEM_WAIT, ack 2 cycles later -> state_o=3 after the ack cycle, and state_o=0 after an asynchronous reset.
